// File: rtl/tb_mmio_periph.sv
// tb_mmio_periph: MMIO test peripheral with exit/stdout registers
// and compare-match timers that raise maskable interrupt lines.
module tb_mmio_periph #(
  parameter int NUM_TIMERS = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic [11:0]           addr_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [31:0]           wdata_i,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  output logic [31:0]           rdata_o,
  output logic [NUM_TIMERS-1:0] irq_o,
  input  logic                  irq_ack_i,
  input  logic [4:0]            irq_ack_id_i,
  output logic                  stdout_valid_o,
  output logic [7:0]            stdout_data_o,
  output logic                  tests_passed_o,
  output logic                  tests_failed_o,
  output logic                  exit_valid_o,
  output logic [31:0]           exit_value_o
);
  localparam int NT = NUM_TIMERS;
  localparam int CW = CNT_WIDTH;

  logic [31:0] bmask;
  logic        wr;
  logic [9:0]  word;
  logic [3:0]  tch;
  logic [1:0]  treg;
  logic        sel_exit, sel_out, sel_pend;
  logic        sel_ien, sel_tmr;

  assign bmask = {{8{be_i[3]}}, {8{be_i[2]}},
                  {8{be_i[1]}}, {8{be_i[0]}}};
  assign wr       = req_i & we_i;
  assign word     = addr_i[11:2];
  assign tch      = addr_i[7:4];
  assign treg     = addr_i[3:2];
  assign sel_exit = word == 10'h000;
  assign sel_out  = word == 10'h001;
  assign sel_pend = word == 10'h002;
  assign sel_ien  = word == 10'h003;
  assign sel_tmr  = addr_i[11:8] == 4'h1;

  logic [CW-1:0] cnt_q [NT];
  logic [CW-1:0] cnt_d [NT];
  logic [CW-1:0] cmp_q [NT];
  logic [CW-1:0] cmp_d [NT];
  logic [CW-1:0] cnt_inc [NT];
  logic [CW-1:0] cmask;
  logic [NT-1:0] en_q, en_d, per_q, per_d;
  logic [NT-1:0] hit, twr;

  assign cmask = bmask[CW-1:0];

  // Software writes are applied after the hardware update so they win.
  always_comb begin
    for (int n = 0; n < NT; n++) begin
      twr[n]     = wr && sel_tmr && tch == 4'(n);
      cnt_inc[n] = cnt_q[n] + CW'(1);
      hit[n]     = en_q[n] && (cmp_q[n] != '0)
                   && (cnt_inc[n] == cmp_q[n]);
      cnt_d[n]   = cnt_q[n];
      cmp_d[n]   = cmp_q[n];
      en_d[n]    = en_q[n];
      per_d[n]   = per_q[n];
      if (hit[n]) begin
        cnt_d[n] = per_q[n] ? '0 : cmp_q[n];
        en_d[n]  = per_q[n];
      end else if (en_q[n]) begin
        cnt_d[n] = cnt_inc[n];
      end
      if (twr[n] && treg == 2'd0 && be_i[0]) begin
        en_d[n]  = wdata_i[0];
        per_d[n] = wdata_i[1];
      end
      if (twr[n] && treg == 2'd1)
        cnt_d[n] = (cnt_d[n] & ~cmask)
                   | (wdata_i[CW-1:0] & cmask);
      if (twr[n] && treg == 2'd2)
        cmp_d[n] = (cmp_q[n] & ~cmask)
                   | (wdata_i[CW-1:0] & cmask);
    end
  end

  logic [NT-1:0] pend_q, pend_d, ien_q, ien_d;
  logic [NT-1:0] irq_q, ack_vec, w1c;

  always_comb begin
    ack_vec = '0;
    for (int n = 0; n < NT; n++)
      ack_vec[n] = irq_ack_i && irq_ack_id_i == 5'(n);
    w1c    = (wr && sel_pend) ? wdata_i[NT-1:0] : '0;
    pend_d = (pend_q & ~w1c & ~ack_vec) | hit;
    ien_d  = ien_q;
    if (wr && sel_ien)
      ien_d = (ien_q & ~bmask[NT-1:0])
              | (wdata_i[NT-1:0] & bmask[NT-1:0]);
  end

  logic        rvalid_q, so_v_q;
  logic [31:0] rdata_q, exit_value_q;
  logic [7:0]  so_d_q;
  logic        exit_valid_q, pass_q, fail_q;
  logic [31:0] trd, rd;

  always_comb begin
    trd = '0;
    for (int n = 0; n < NT; n++) begin
      if (sel_tmr && tch == 4'(n)) begin
        case (treg)
          2'd0:    trd = {30'd0, per_q[n], en_q[n]};
          2'd1:    trd = 32'(cnt_q[n]);
          2'd2:    trd = 32'(cmp_q[n]);
          default: trd = '0;
        endcase
      end
    end
  end

  always_comb begin
    unique case (1'b1)
      sel_exit: rd = exit_value_q;
      sel_pend: rd = 32'(pend_q);
      sel_ien:  rd = 32'(ien_q);
      sel_tmr:  rd = trd;
      default:  rd = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      so_v_q       <= 1'b0;
      so_d_q       <= '0;
      exit_valid_q <= 1'b0;
      exit_value_q <= '0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      pend_q       <= '0;
      ien_q        <= '0;
      irq_q        <= '0;
      en_q         <= '0;
      per_q        <= '0;
      for (int n = 0; n < NT; n++) begin
        cnt_q[n] <= '0;
        cmp_q[n] <= '0;
      end
    end else begin
      rvalid_q <= req_i;
      rdata_q  <= (req_i && !we_i) ? rd : '0;
      so_v_q   <= wr && sel_out && be_i[0];
      if (wr && sel_out && be_i[0])
        so_d_q <= wdata_i[7:0];
      if (wr && sel_exit && !exit_valid_q) begin
        exit_valid_q <= 1'b1;
        exit_value_q <= wdata_i;
        pass_q       <= wdata_i == 32'd0;
        fail_q       <= wdata_i != 32'd0;
      end
      pend_q <= pend_d;
      ien_q  <= ien_d;
      irq_q  <= pend_q & ien_q;
      en_q   <= en_d;
      per_q  <= per_d;
      for (int n = 0; n < NT; n++) begin
        cnt_q[n] <= cnt_d[n];
        cmp_q[n] <= cmp_d[n];
      end
    end
  end

  assign gnt_o          = req_i;
  assign rvalid_o       = rvalid_q;
  assign rdata_o        = rvalid_q ? rdata_q : '0;
  assign irq_o          = irq_q;
  assign stdout_valid_o = so_v_q;
  assign stdout_data_o  = so_d_q;
  assign exit_valid_o   = exit_valid_q;
  assign exit_value_o   = exit_value_q;
  assign tests_passed_o = pass_q;
  assign tests_failed_o = fail_q;

  logic unused_ok;
  assign unused_ok = ^{addr_i[1:0], wdata_i, bmask};
endmodule

// File: tb/tb_tb_mmio_periph.sv
// tb_tb_mmio_periph: directed and random checks of tb_mmio_periph
// against a cycle-level register-map reference model.
module tb_tb_mmio_periph;
  localparam int NT   = 4;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic req, we, ack;
  logic [11:0] addr;
  logic [3:0] be;
  logic [31:0] wdata;
  logic [4:0] ack_id;
  logic gnt, rvalid, so_v, pass, fail, ex_v;
  logic [31:0] rdata, ex_val;
  logic [NT-1:0] irq;
  logic [7:0] so_d;
  logic [31:0] d;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tb_mmio_periph #(.NUM_TIMERS(NT), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_i(req), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .irq_o(irq), .irq_ack_i(ack), .irq_ack_id_i(ack_id),
    .stdout_valid_o(so_v), .stdout_data_o(so_d),
    .tests_passed_o(pass), .tests_failed_o(fail),
    .exit_valid_o(ex_v), .exit_value_o(ex_val)
  );

  int m_cnt [NT];
  int m_cmp [NT];
  bit m_en [NT];
  bit m_per [NT];
  int m_pend, m_ien, m_irq, m_sd;
  bit m_rv, m_xv, m_sv;
  logic [31:0] m_rd, m_xval;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NT; i++) begin
      m_cnt[i] = 0; m_cmp[i] = 0;
      m_en[i] = 0;  m_per[i] = 0;
    end
    m_pend = 0; m_ien = 0; m_irq = 0; m_sd = 0;
    m_rv = 0; m_xv = 0; m_sv = 0;
    m_rd = 0; m_xval = 0;
  endtask

  function automatic logic [31:0] rd_model(input int off);
    int n;
    if (off == 0) return m_xval;
    if (off == 'h8) return 32'(m_pend);
    if (off == 'hC) return 32'(m_ien);
    if (off >= 'h100 && off < 'h100 + 16 * NT) begin
      n = (off - 'h100) >> 4;
      case (off & 'hC)
        0: return 32'(int'(m_en[n]) + 2 * int'(m_per[n]));
        4: return 32'(m_cnt[n]);
        8: return 32'(m_cmp[n]);
        default: return 32'd0;
      endcase
    end
    return 32'd0;
  endfunction

  // One clock edge of the register map, from pre-edge state and inputs.
  task automatic model_step();
    logic [31:0] bm;
    int off, cm, hit, op, oi, nx, n;
    bit wr;
    wr  = req && we;
    off = int'(addr) & 'hFFC;
    bm  = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    hit = 0; op = m_pend; oi = m_ien;
    m_rv = req;
    m_rd = (req && !we) ? rd_model(off) : 32'd0;
    m_irq = op & oi;
    for (int i = 0; i < NT; i++) begin
      nx = (m_cnt[i] + 1) % (CMAX + 1);
      if (m_en[i] && m_cmp[i] != 0 && nx == m_cmp[i]) begin
        hit |= 1 << i;
        m_cnt[i] = m_per[i] ? 0 : m_cmp[i];
        m_en[i] = m_per[i];
      end else if (m_en[i]) begin
        m_cnt[i] = nx;
      end
    end
    if (wr && off >= 'h100 && off < 'h100 + 16 * NT) begin
      n = (off - 'h100) >> 4;
      cm = int'(bm) & CMAX;
      case (off & 'hC)
        0: if (be[0]) begin
             m_en[n] = wdata[0]; m_per[n] = wdata[1];
           end
        4: m_cnt[n] = (m_cnt[n] & ~cm) | (int'(wdata) & cm);
        8: m_cmp[n] = (m_cmp[n] & ~cm) | (int'(wdata) & cm);
        default: ;
      endcase
    end
    if (wr && off == 'h8) m_pend &= ~int'(wdata);
    if (ack && int'(ack_id) < NT) m_pend &= ~(1 << ack_id);
    m_pend = (m_pend | hit) & ((1 << NT) - 1);
    if (wr && off == 'hC) begin
      cm = int'(bm) & ((1 << NT) - 1);
      m_ien = (m_ien & ~cm) | (int'(wdata) & cm);
    end
    if (wr && off == 0 && !m_xv) begin
      m_xv = 1; m_xval = wdata;
    end
    m_sv = wr && off == 4 && be[0];
    if (m_sv) m_sd = int'(wdata[7:0]);
  endtask

  task automatic check_all();
    chk("gnt", 32'(gnt), 32'(req));
    chk("rvalid", 32'(rvalid), 32'(m_rv));
    chk("rdata", rdata, m_rd);
    chk("irq", 32'(irq), 32'(m_irq));
    chk("so_valid", 32'(so_v), 32'(m_sv));
    if (m_sv) chk("so_data", 32'(so_d), 32'(m_sd));
    chk("exit_valid", 32'(ex_v), 32'(m_xv));
    chk("exit_value", ex_val, m_xval);
    chk("passed", 32'(pass), 32'(m_xv && m_xval == 0));
    chk("failed", 32'(fail), 32'(m_xv && m_xval != 0));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic bus(input logic w, input logic [11:0] a,
                     input logic [3:0] b, input logic [31:0] v);
    req = 1; we = w; addr = a; be = b; wdata = v;
    step();
    req = 0; we = 0; addr = 0; be = 0; wdata = 0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] v);
    bus(1'b0, a, 4'h0, 32'd0);
    v = rdata;
  endtask

  task automatic do_reset();
    req = 0; we = 0; addr = 0; be = 0; wdata = 0;
    ack = 0; ack_id = 0;
    rst_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    do_reset();
    chk("rst_exit_valid", 32'(ex_v), 32'd0);

    bus(1, 12'h000, 4'hF, 32'h0);
    chk("exit0_passed", 32'(pass), 32'd1);
    chk("exit0_value", ex_val, 32'd0);
    bus(1, 12'h000, 4'hF, 32'h5);
    idle(1);
    chk("exit_sticky", ex_val, 32'd0);
    chk("exit_nofail", 32'(fail), 32'd0);
    do_reset();
    bus(1, 12'h000, 4'hF, 32'h7);
    chk("exit7_failed", 32'(fail), 32'd1);
    chk("exit7_value", ex_val, 32'd7);
    do_reset();

    bus(1, 12'h004, 4'hF, 32'h41);
    chk("so_pulse", 32'(so_v), 32'd1);
    chk("so_char", 32'(so_d), 32'h41);
    idle(1);
    chk("so_once", 32'(so_v), 32'd0);
    bus(1, 12'h004, 4'hE, 32'h41);
    chk("so_be_off", 32'(so_v), 32'd0);

    bus(1, 12'h108, 4'hF, 32'd10);
    bus(1, 12'h00C, 4'hF, 32'd1);
    bus(1, 12'h100, 4'hF, 32'd1);
    idle(10);
    chk("t0_irq_early", 32'(irq[0]), 32'd0);
    idle(1);
    chk("t0_irq", 32'(irq[0]), 32'd1);
    rd(12'h008, d);
    chk("t0_pend", d, 32'd1);
    rd(12'h100, d);
    chk("t0_en_clr", d, 32'd0);
    rd(12'h104, d);
    chk("t0_count", d, 32'd10);
    bus(1, 12'h008, 4'hF, 32'h1);

    bus(1, 12'h00C, 4'hF, 32'd3);
    bus(1, 12'h118, 4'hF, 32'd3);
    bus(1, 12'h110, 4'hF, 32'd3);
    idle(2);
    bus(1, 12'h008, 4'hF, 32'h2);
    rd(12'h008, d);
    chk("w1c_vs_match", 32'(d[1]), 32'd1);
    bus(1, 12'h008, 4'hF, 32'h2);
    rd(12'h008, d);
    chk("w1c_clear", 32'(d[1]), 32'd0);
    rd(12'h008, d);
    chk("t1_periodic", 32'(d[1]), 32'd1);
    bus(1, 12'h110, 4'hF, 32'd0);

    bus(1, 12'h128, 4'hF, 32'h01);
    bus(1, 12'h124, 4'hF, 32'hFE);
    bus(1, 12'h120, 4'hF, 32'h1);
    rd(12'h124, d);
    chk("wrap_fe", d, 32'hFE);
    rd(12'h124, d);
    chk("wrap_ff", d, 32'hFF);
    rd(12'h124, d);
    chk("wrap_00", d, 32'h00);
    rd(12'h124, d);
    chk("wrap_hit", d, 32'h01);
    rd(12'h120, d);
    chk("wrap_en_clr", d, 32'd0);

    rd(12'h008, d);
    chk("pend_0110", d, 32'h6);
    ack = 1; ack_id = 5'd2;
    idle(1);
    ack = 0;
    rd(12'h008, d);
    chk("ack_id2", d, 32'h2);
    ack = 1; ack_id = 5'd9;
    idle(1);
    ack = 0;
    rd(12'h008, d);
    chk("ack_oob", d, 32'h2);

    bus(1, 12'h134, 4'hF, 32'h1234);
    rd(12'h134, d);
    chk("cnt_width", d, 32'h34);
    bus(1, 12'h148, 4'hF, 32'h5);
    rd(12'h148, d);
    chk("chan_unmapped", d, 32'd0);

    req = 1; we = 0; addr = 12'h008;
    @(posedge clk);
    model_step();
    #2;
    rst_n = 0;
    model_reset();
    #1;
    check_all();
    chk("rst_mid_rvalid", 32'(rvalid), 32'd0);
    req = 0;
    @(negedge clk);
    rst_n = 1;
    step();
    chk("no_rvalid_after", 32'(rvalid), 32'd0);

    do_reset();
    repeat (1500) begin
      req = $urandom_range(0, 9) < 6;
      we = $urandom_range(0, 1) == 1;
      be = 4'($urandom);
      case ($urandom_range(0, 5))
        0: addr = 12'($urandom_range(0, 3) * 4);
        1, 2, 3: addr = 12'('h100 + $urandom_range(0, NT) * 16
                             + $urandom_range(0, 3) * 4);
        4: addr = 12'('h8 + $urandom_range(0, 1) * 4);
        default: addr = 12'($urandom);
      endcase
      addr[1:0] = 2'($urandom);
      wdata = ($urandom_range(0, 3) == 0) ? $urandom
                                          : $urandom_range(0, 24);
      ack = $urandom_range(0, 9) == 0;
      ack_id = 5'($urandom_range(0, 7));
      step();
    end
    req = 0; ack = 0;
    idle(2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/tb_mmio_periph.md
TB_MMIO_PERIPH -- requirements
Module: tb_mmio_periph

Interface
REQ-001 SHALL have parameter NUM_TIMERS, default 4, number of timer/interrupt channels, legal range 1..16.
REQ-002 SHALL have parameter CNT_WIDTH, default 32, timer counter width, legal range 8..32.
REQ-003 SHALL have ports clk_i (in, 1, sole clock) and rst_ni (in, 1): one clock; reset is asynchronous and active-low.
REQ-004 SHALL have the data-port inputs:
- req_i (1): request.
- addr_i (12): byte offset.
- we_i (1): write.
- be_i (4): byte enables.
- wdata_i (32): write data.
REQ-005 SHALL have gnt_o (out, 1), rvalid_o (out, 1) and rdata_o (out, 32): grant, response valid, read data.
REQ-006 SHALL have irq_o (out, NUM_TIMERS): interrupt lines to the core.
REQ-007 SHALL have irq_ack_i (in, 1) and irq_ack_id_i (in, 5): core interrupt acknowledge and the acknowledged channel.
REQ-008 SHALL have stdout_valid_o (out, 1) and stdout_data_o (out, 8): character output strobe and character.
REQ-009 SHALL have tests_passed_o, tests_failed_o and exit_valid_o (out, 1 each), and exit_value_o (out, 32): test status.

Function
REQ-010 SHALL drive gnt_o = req_i combinationally; every request SHALL be granted in its cycle.
REQ-011 SHALL assert rvalid_o exactly one cycle after each grant, for reads and writes; writes SHALL return rdata_o = 0.
REQ-012 SHALL drive rdata_o = 0 whenever rvalid_o is low.
REQ-013 SHALL use this register map (offsets; addr_i[1:0] ignored):
- 0x000 EXIT
- 0x004 STDOUT
- 0x008 IRQ_PENDING
- 0x00C IRQ_ENABLE
- 0x100+0x10*n timer n: +0x0 CTRL (bit0 EN, bit1 PERIODIC), +0x4 COUNT, +0x8 COMPARE.
REQ-014 SHALL read unmapped offsets, and channels n >= NUM_TIMERS, as 0; writes to them SHALL be ignored; the access still receives rvalid_o.
REQ-015 SHALL apply be_i per byte on writes to COUNT, COMPARE, CTRL and IRQ_ENABLE; bits at or above CNT_WIDTH/NUM_TIMERS SHALL be ignored on write and read as 0.
REQ-016 SHALL, on the first write to EXIT:
- set exit_valid_o = 1 and exit_value_o = wdata_i;
- set tests_passed_o = (wdata_i == 0) and tests_failed_o = (wdata_i != 0);
- hold all four sticky until reset; later EXIT writes SHALL be ignored.
REQ-017 SHALL, on a write to STDOUT with be_i[0] = 1, pulse stdout_valid_o for exactly one cycle (the cycle after the grant) with stdout_data_o = wdata_i[7:0] held in that cycle.
REQ-018 SHALL, while timer n CTRL.EN = 1, increment COUNT by 1 per cycle, wrapping from 2^CNT_WIDTH-1 to 0.
REQ-019 SHALL detect a match when EN = 1, COMPARE != 0 and the incremented COUNT value equals COMPARE; on a match:
- pending[n] SHALL set;
- if PERIODIC = 1, COUNT SHALL load 0 and stay enabled;
- otherwise EN SHALL clear and COUNT SHALL hold COMPARE.
REQ-020 SHALL never fire a timer with COMPARE = 0.
REQ-021 SHALL give a software write to COUNT or CTRL priority over the hardware increment/clear in the same cycle.
REQ-022 SHALL clear pending bits via IRQ_PENDING write-1-to-clear, and via irq_ack_i clearing pending[irq_ack_id_i] (ids >= NUM_TIMERS ignored).
REQ-023 SHALL give a match priority over a clear in the same cycle (the bit stays set).
REQ-024 SHALL register irq_o = pending & enable, so irq_o rises one cycle after pending sets.
REQ-025 SHALL allow all timers to advance and match independently in the same cycle.

Reset
REQ-026 SHALL, while rst_ni = 0, asynchronously force to 0:
- all outputs except gnt_o;
- all COUNT, COMPARE and CTRL registers;
- pending and enable.
REQ-027 SHALL drop any outstanding response if reset asserts mid-transaction: no rvalid_o after reset release.

Verification
REQ-028 SHALL cover: EXIT write 0x0 then 0x5 -> tests_passed_o = 1, exit_value_o = 0, second write ignored; separately, EXIT write 0x7 -> tests_failed_o = 1.
REQ-029 SHALL cover: STDOUT write 0x41 with be_i = 0xF -> one-cycle stdout_valid_o with data 0x41; the same write with be_i = 0xE -> no pulse.
REQ-030 SHALL cover: timer0 COMPARE = 10, IRQ_ENABLE = 1, CTRL = 0x1 -> pending[0] set 10 cycles after the CTRL write, irq_o[0] one cycle later, EN reads 0, COUNT reads 10.
REQ-031 SHALL cover: timer1 COMPARE = 3, CTRL = 0x3 -> pending sets every 3 cycles; a W1C of pending in a match cycle leaves the bit set.
REQ-032 SHALL cover: CNT_WIDTH = 8, COUNT = 0xFE, COMPARE = 0x01, EN -> COUNT wraps through 0x00, match at 0x01.
REQ-033 SHALL cover: irq_ack_i with id 2 while pending = 0b0110 -> pending = 0b0010; rst_ni low mid-read -> no rvalid_o, all outputs 0.
